// File: rtl/aes_pkg.sv
// Shared AES datapath types: block/byte widths, the matching typedefs and the
// block serializer state encoding.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_BYTE_W-1:0]  aes_byte_t;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_e;

endpackage

// File: rtl/aes_block_serializer.sv
// AES block serializer: takes a whole block on a valid/ready block interface
// and streams it out as BLOCK_W/BYTE_W beats on a valid/ready byte interface.
// The last beat of one block can hand over directly to the next block, so a
// continuous supply of blocks streams with no idle cycle between them.
module aes_block_serializer
    import aes_pkg::*;
#(
    parameter int BLOCK_W   = AES_BLOCK_W,
    parameter int BYTE_W    = AES_BYTE_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic [BYTE_W-1:0]  byte_data,
    output logic               byte_last,
    output logic               busy
);

    localparam int N_BEATS = BLOCK_W / BYTE_W;
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

    ser_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] shreg_q, shreg_d;

    logic last_beat;
    logic blk_hs;
    logic beat_hs;

    assign last_beat = (cnt_q == LAST_CNT);
    assign blk_hs    = blk_valid && blk_ready;
    assign beat_hs   = byte_valid && byte_ready;

    // The head of the shift register is the current beat; the register is
    // cleared in reset and after the final beat, so idle byte_data reads 0.
    assign byte_data = MSB_FIRST ? shreg_q[BLOCK_W-1 -: BYTE_W] : shreg_q[BYTE_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= SER_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept a block when idle; after the final beat either chain
    // straight into the next block or fall back to idle.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            SER_IDLE: if (blk_valid)                           state_d = SER_SEND;
            SER_SEND: if (beat_hs && last_beat && !blk_valid)  state_d = SER_IDLE;
            default:                                            state_d = SER_IDLE;
        endcase
    end

    // Outputs decoded from state; blk_ready opens during SEND only when the
    // final beat is being taken, so the next block can load on the same edge.
    always_comb begin
        blk_ready  = 1'b0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            SER_IDLE: begin
                blk_ready = 1'b1;
            end
            SER_SEND: begin
                byte_valid = 1'b1;
                byte_last  = last_beat;
                busy       = 1'b1;
                blk_ready  = last_beat && byte_ready;
            end
            default: ;
        endcase
    end

    // Datapath next state: load on a block handshake, advance on a beat
    // handshake, clear after the final beat; hold while stalled.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (blk_hs) begin
            shreg_d = blk_data;
            cnt_d   = '0;
        end else if (beat_hs) begin
            if (last_beat) begin
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                shreg_d = MSB_FIRST ? (shreg_q << BYTE_W) : (shreg_q >> BYTE_W);
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // Shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // Beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Self-checking bench for aes_block_serializer. Two instances (MSB-first and
// LSB-first) share the inputs; a queue-based reference model predicts every
// beat from the accepted blocks and is compared cycle by cycle.
module tb_aes_block_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         byte_ready;

    logic       m_blk_ready, m_byte_valid, m_byte_last, m_busy;
    logic [7:0] m_byte_data;
    logic       l_blk_ready, l_byte_valid, l_byte_last, l_busy;
    logic [7:0] l_byte_data;

    always #5 clk = ~clk;

    aes_block_serializer #(.BLOCK_W(128), .BYTE_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid), .blk_ready(m_blk_ready), .blk_data(blk_data),
        .byte_valid(m_byte_valid), .byte_ready(byte_ready), .byte_data(m_byte_data),
        .byte_last(m_byte_last), .busy(m_busy)
    );

    aes_block_serializer #(.BLOCK_W(128), .BYTE_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid), .blk_ready(l_blk_ready), .blk_data(blk_data),
        .byte_valid(l_byte_valid), .byte_ready(byte_ready), .byte_data(l_byte_data),
        .byte_last(l_byte_last), .busy(l_busy)
    );

    // Observed outputs of whichever instance is under test.
    bit         use_lsb = 1'b0;
    logic       o_blk_ready, o_valid, o_last, o_busy;
    logic [7:0] o_data;

    always_comb begin
        o_blk_ready = use_lsb ? l_blk_ready  : m_blk_ready;
        o_valid     = use_lsb ? l_byte_valid : m_byte_valid;
        o_last      = use_lsb ? l_byte_last  : m_byte_last;
        o_busy      = use_lsb ? l_busy       : m_busy;
        o_data      = use_lsb ? l_byte_data  : m_byte_data;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] blk_q[$];   // blocks waiting to be offered
    logic [7:0]   exp_q[$];   // beats still owed by the DUT, in order
    int           hs_cyc[$];  // cycle index of each block handshake
    logic [7:0]   first_byte, last_byte;
    int           beats_done;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Beat k of a block: MSB-first takes bytes from the top, LSB-first from the bottom.
    function automatic logic [7:0] model_byte(input logic [127:0] blk, input int k, input bit lsb);
        logic [127:0] sh;
        sh = lsb ? (blk >> (8 * k)) : (blk >> (8 * (15 - k)));
        return sh[7:0];
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer every block in blk_q (blk_valid held while any remain) and check
    // all outputs every cycle against the model. mode: 0 = ready always,
    // 1 = ready pattern 1,0,0,1, 2 = random ready. stop_after > 0 ends the run
    // right after that many beats have been taken.
    task automatic run_stream(input int mode, input int stop_after, input int max_cycles);
        int           cyc;
        int           idle;
        bit           stalled;
        logic [7:0]   held;
        logic [127:0] b;
        cyc        = 0;
        idle       = 0;
        stalled    = 1'b0;
        held       = '0;
        beats_done = 0;
        hs_cyc.delete();
        while (1) begin
            blk_valid = (blk_q.size() > 0);
            blk_data  = blk_valid ? blk_q[0] : rand_block();
            case (mode)
                0:       byte_ready = 1'b1;
                1:       byte_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            check("byte_valid", 128'(o_valid), 128'(exp_q.size() > 0));
            check("busy", 128'(o_busy), 128'(exp_q.size() > 0));
            check("blk_ready", 128'(o_blk_ready),
                  128'((exp_q.size() == 0) || (exp_q.size() == 1 && byte_ready)));
            if (exp_q.size() > 0) begin
                check("byte_data", 128'(o_data), 128'(exp_q[0]));
                check("byte_last", 128'(o_last), 128'(exp_q.size() == 1));
            end
            if (stalled) check("stall_hold", 128'(o_data), 128'(held));
            stalled = o_valid && !byte_ready;
            held    = o_data;
            if (o_valid && byte_ready && exp_q.size() > 0) begin
                if (beats_done == 0) first_byte = o_data;
                last_byte = o_data;
                beats_done++;
                void'(exp_q.pop_front());
            end
            if (blk_valid && o_blk_ready) begin
                b = blk_q.pop_front();
                hs_cyc.push_back(cyc);
                for (int k = 0; k < 16; k++) exp_q.push_back(model_byte(b, k, use_lsb));
            end
            @(posedge clk);
            #1;
            cyc++;
            if (stop_after > 0 && beats_done == stop_after) break;
            if (blk_q.size() == 0 && exp_q.size() == 0) begin
                idle++;
                if (idle > 2) break;
            end
            if (cyc >= max_cycles) begin
                check("timeout_pending", 128'(exp_q.size() + blk_q.size()), 128'(0));
                break;
            end
        end
        blk_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 128'(o_valid), 128'(0));
        check({tag, "_busy"},  128'(o_busy),  128'(0));
        check({tag, "_last"},  128'(o_last),  128'(0));
        check({tag, "_data"},  128'(o_data),  128'(0));
    endtask

    logic [127:0] blk_t;

    initial begin
        // Reset held 3 cycles with a block offered: nothing may be accepted.
        rst_n      = 1'b0;
        blk_valid  = 1'b1;
        blk_data   = 128'h00112233445566778899aabbccddeeff;
        byte_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // Basic MSB-first stream; handshake on the first cycle after release.
        blk_q.push_back(128'h00112233445566778899aabbccddeeff);
        run_stream(0, 0, 200);
        check("t1_first_hs_cycle", 128'(hs_cyc[0]), 128'(0));
        check("t1_first", 128'(first_byte), 128'(8'h00));
        check("t1_last",  128'(last_byte),  128'(8'hff));
        check("t1_beats", 128'(beats_done), 128'(16));

        // Backpressure pattern 1,0,0,1.
        blk_q.push_back(128'h00112233445566778899aabbccddeeff);
        run_stream(1, 0, 400);
        check("t2_beats", 128'(beats_done), 128'(16));
        check("t2_last",  128'(last_byte),  128'(8'hff));

        // Back-to-back blocks: second handshake exactly 16 cycles after the first.
        blk_q.push_back(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        blk_q.push_back(128'h3243f6a8885a308d313198a2e0370734);
        run_stream(0, 0, 300);
        check("t3_hs_count", 128'(hs_cyc.size()), 128'(2));
        if (hs_cyc.size() == 2) check("t3_hs_gap", 128'(hs_cyc[1] - hs_cyc[0]), 128'(16));
        check("t3_beats", 128'(beats_done), 128'(32));
        check("t3_last",  128'(last_byte),  128'(8'h34));

        // LSB-first instance.
        use_lsb = 1'b1;
        blk_q.push_back(128'h000102030405060708090a0b0c0d0e0f);
        run_stream(0, 0, 200);
        check("t4_first", 128'(first_byte), 128'(8'h0f));
        check("t4_last",  128'(last_byte),  128'(8'h00));
        check("t4_beats", 128'(beats_done), 128'(16));

        // Random blocks under random backpressure, both orders.
        for (int r = 0; r < 4; r++) begin
            use_lsb = r[0];
            for (int j = 0; j < 3; j++) blk_q.push_back(rand_block());
            run_stream(2, 0, 1000);
            check("rand_beats", 128'(beats_done), 128'(48));
        end

        // Reset after beat 5: outputs clear next cycle, a new block starts fresh.
        use_lsb = 1'b0;
        blk_q.push_back(rand_block());
        run_stream(0, 5, 200);
        check("t5_beats_before_rst", 128'(beats_done), 128'(5));
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("t5_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        blk_q.delete();
        blk_t = rand_block();
        blk_q.push_back(blk_t);
        run_stream(2, 0, 400);
        check("t5_first", 128'(first_byte), 128'(model_byte(blk_t, 0, 1'b0)));
        check("t5_last",  128'(last_byte),  128'(model_byte(blk_t, 15, 1'b0)));
        check("t5_beats", 128'(beats_done), 128'(16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
